// File: rtl/tkeep_decode_skid_pkg.sv
// Shared tkeep coder definitions: log2, encoded-count-to-mask decode, skid states.
// Used by tkeep_decode_skid and axis_skid_reg.
package tkeep_decode_skid_pkg;

    localparam int DEFAULT_DATA_W = 256;
    // Widest strobe the decode helper supports (1024-bit data); callers cast down.
    localparam int MAX_STRB_W     = 128;

    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    localparam int DEFAULT_STRB_W      = DEFAULT_DATA_W / 8;
    localparam int DEFAULT_TKEEP_ENC_W = log2(DEFAULT_STRB_W);

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    // Inverse of the tkeep encoder: value k marks bytes 0..k valid.
    function automatic logic [MAX_STRB_W-1:0] decode_tkeep(input logic [31:0] enc);
        logic [MAX_STRB_W-1:0] mask;
        for (int i = 0; i < MAX_STRB_W; i++) begin
            mask[i] = (32'(i) <= enc);
        end
        return mask;
    endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Generic 2-entry skid register: main entry drives the master side, skid entry
// absorbs one beat of backpressure so both valid and ready are registered.
module axis_skid_reg
    import tkeep_decode_skid_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         axi_aclk,
    input  logic         axi_resetn,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready
);

    skid_state_e  state;
    logic [W-1:0] skid_data;
    logic         s_fire;
    logic         m_fire;

    assign s_fire = s_valid && s_ready;
    assign m_fire = m_valid && m_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch below sees the pre-edge values of state, m_valid and s_ready.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state     <= SKID_EMPTY;
            s_ready   <= 1'b0;
            m_valid   <= 1'b0;
            // NOTE: the payload registers are reset too; they are plain flops,
            // not a RAM, and downstream expects zeroed data after reset.
            m_data    <= '0;
            skid_data <= '0;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    s_ready <= 1'b1;
                    if (s_fire) begin
                        m_data  <= s_data;
                        m_valid <= 1'b1;
                        state   <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (s_fire && !m_fire) begin
                        skid_data <= s_data;
                        s_ready   <= 1'b0;
                        state     <= SKID_TWO;
                    end else begin
                        s_ready <= 1'b1;
                        if (s_fire) begin
                            m_data <= s_data;
                        end else if (m_fire) begin
                            m_valid <= 1'b0;
                            state   <= SKID_EMPTY;
                        end
                    end
                end
                SKID_TWO: begin
                    // Input is never accepted here; s_ready is already low.
                    if (m_fire) begin
                        m_data  <= skid_data;
                        s_ready <= 1'b1;
                        state   <= SKID_ONE;
                    end
                end
                default: begin
                    state   <= SKID_EMPTY;
                    m_valid <= 1'b0;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/tkeep_decode_skid.sv
// Receive stage: expands the encoded byte count to a tkeep mask and forwards the beat
// through a skid register. Optional length check: define TKEEP_DECODE_LENGTH_CHECK_EN.
module tkeep_decode_skid
    import tkeep_decode_skid_pkg::*;
#(
    parameter int C_INPORT_WIDTH        = 3,
    parameter int C_OUTPORT_WIDTH       = 8,
    parameter int C_PACKET_LENGTH_WIDTH = 14,
    parameter int C_AXIS_DATA_WIDTH     = DEFAULT_DATA_W
) (
    input  logic                                   axi_aclk,
    input  logic                                   axi_resetn,

    input  logic [C_AXIS_DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic [log2(C_AXIS_DATA_WIDTH/8)-1:0]   s_axis_tkeep_enc,
    input  logic [C_PACKET_LENGTH_WIDTH-1:0]       s_axis_tuser_packet_length,
    input  logic [C_INPORT_WIDTH-1:0]              s_axis_tuser_in_port,
    input  logic [C_OUTPORT_WIDTH-1:0]             s_axis_tuser_out_port,
    input  logic [C_INPORT_WIDTH-1:0]              s_axis_tuser_in_vport,
    input  logic [C_OUTPORT_WIDTH-1:0]             s_axis_tuser_out_vport,
    input  logic                                   s_axis_tvalid,
    output logic                                   s_axis_tready,
    input  logic                                   s_axis_tlast,

    output logic [C_AXIS_DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]         m_axis_tkeep,
    output logic [C_PACKET_LENGTH_WIDTH-1:0]       m_axis_tuser_packet_length,
    output logic [C_INPORT_WIDTH-1:0]              m_axis_tuser_in_port,
    output logic [C_OUTPORT_WIDTH-1:0]             m_axis_tuser_out_port,
    output logic [C_INPORT_WIDTH-1:0]              m_axis_tuser_in_vport,
    output logic [C_OUTPORT_WIDTH-1:0]             m_axis_tuser_out_vport,
    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready,
`ifdef TKEEP_DECODE_LENGTH_CHECK_EN
    output logic                                   err_length,
`endif
    output logic                                   m_axis_tlast
);

    localparam int STRB_W    = C_AXIS_DATA_WIDTH / 8;
    localparam int PAYLOAD_W = C_AXIS_DATA_WIDTH + STRB_W + C_PACKET_LENGTH_WIDTH
                             + 2 * C_INPORT_WIDTH + 2 * C_OUTPORT_WIDTH + 1;

    logic [STRB_W-1:0]    s_keep;
    logic [PAYLOAD_W-1:0] s_payload;
    logic [PAYLOAD_W-1:0] m_payload;

    // Decoding ahead of the capture flops keeps m_axis_tkeep purely registered.
    assign s_keep = STRB_W'(decode_tkeep(32'(s_axis_tkeep_enc)));

    assign s_payload = {s_axis_tdata, s_keep, s_axis_tuser_packet_length,
                        s_axis_tuser_in_port, s_axis_tuser_out_port,
                        s_axis_tuser_in_vport, s_axis_tuser_out_vport, s_axis_tlast};

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser_packet_length,
            m_axis_tuser_in_port, m_axis_tuser_out_port,
            m_axis_tuser_in_vport, m_axis_tuser_out_vport, m_axis_tlast} = m_payload;

    axis_skid_reg #(
        .W (PAYLOAD_W)
    ) u_skid (
        .axi_aclk   (axi_aclk),
        .axi_resetn (axi_resetn),
        .s_data     (s_payload),
        .s_valid    (s_axis_tvalid),
        .s_ready    (s_axis_tready),
        .m_data     (m_payload),
        .m_valid    (m_axis_tvalid),
        .m_ready    (m_axis_tready)
    );

`ifdef TKEEP_DECODE_LENGTH_CHECK_EN
    localparam int CNT_W = C_PACKET_LENGTH_WIDTH + 1;

    logic [CNT_W-1:0]                 byte_cnt;
    logic [C_PACKET_LENGTH_WIDTH-1:0] len_latched;
    logic                             first_beat;
    logic                             s_fire;
    logic [CNT_W:0]                   sum_wide;
    logic [CNT_W-1:0]                 sum_sat;
    logic [C_PACKET_LENGTH_WIDTH-1:0] len_ref;

    assign s_fire = s_axis_tvalid && s_axis_tready;

    // NOTE: every always_comb output gets a value on every path, so no latch
    // is inferred.
    always_comb begin
        sum_wide = {1'b0, byte_cnt} + (CNT_W + 1)'(s_axis_tkeep_enc) + (CNT_W + 1)'(1);
        sum_sat  = sum_wide[CNT_W] ? '1 : sum_wide[CNT_W-1:0];
        // A single-beat packet compares against its own length field.
        len_ref  = first_beat ? s_axis_tuser_packet_length : len_latched;
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            byte_cnt    <= '0;
            len_latched <= '0;
            first_beat  <= 1'b1;
            err_length  <= 1'b0;
        end else begin
            err_length <= 1'b0;
            if (s_fire) begin
                if (first_beat) len_latched <= s_axis_tuser_packet_length;
                if (s_axis_tlast) begin
                    err_length <= (sum_sat != {1'b0, len_ref});
                    byte_cnt   <= '0;
                    first_beat <= 1'b1;
                end else begin
                    byte_cnt   <= sum_sat;
                    first_beat <= 1'b0;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_tkeep_decode_skid.sv
// Scoreboard bench for tkeep_decode_skid: directed scenarios plus randomized
// valid/ready traffic checked against a byte-count reference model.
`timescale 1ns/1ps
module tb_tkeep_decode_skid;
    import tkeep_decode_skid_pkg::*;

    localparam int DW  = DEFAULT_DATA_W;
    localparam int SW  = DEFAULT_STRB_W;
    localparam int EW  = DEFAULT_TKEEP_ENC_W;
    localparam int PLW = 14;
    localparam int IPW = 3;
    localparam int OPW = 8;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [SW-1:0]  keep;
        logic [PLW-1:0] plen;
        logic [IPW-1:0] in_port;
        logic [OPW-1:0] out_port;
        logic [IPW-1:0] in_vport;
        logic [OPW-1:0] out_vport;
        logic           last;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [EW-1:0]  enc;
        logic [PLW-1:0] plen;
        logic [IPW-1:0] in_port;
        logic [OPW-1:0] out_port;
        logic [IPW-1:0] in_vport;
        logic [OPW-1:0] out_vport;
        logic           last;
    } stim_t;

    typedef struct {
        beat_t beat;
        int    acc_cyc;
    } exp_t;

    logic           aclk;
    logic           resetn;
    logic [DW-1:0]  s_tdata;
    logic [EW-1:0]  s_tkeep_enc;
    logic [PLW-1:0] s_plen;
    logic [IPW-1:0] s_in_port, s_in_vport;
    logic [OPW-1:0] s_out_port, s_out_vport;
    logic           s_tvalid, s_tready, s_tlast;
    logic [DW-1:0]  m_tdata;
    logic [SW-1:0]  m_tkeep;
    logic [PLW-1:0] m_plen;
    logic [IPW-1:0] m_in_port, m_in_vport;
    logic [OPW-1:0] m_out_port, m_out_vport;
    logic           m_tvalid, m_tready, m_tlast;
`ifdef TKEEP_DECODE_LENGTH_CHECK_EN
    logic           err_length;
    int             err_seen = 0;
    int             exp_err  = 0;
`endif

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    exp_t  expq[$];
    int    pop_cyc[$];
    int    last_latency = 0;
    beat_t last_beat;
    int    beats_sent = 0;

    // Reference model state for the packet byte count.
    bit       mdl_first = 1'b1;
    int       mdl_sum   = 0;
    int       mdl_len   = 0;

    tkeep_decode_skid dut (
        .axi_aclk                   (aclk),
        .axi_resetn                 (resetn),
        .s_axis_tdata               (s_tdata),
        .s_axis_tkeep_enc           (s_tkeep_enc),
        .s_axis_tuser_packet_length (s_plen),
        .s_axis_tuser_in_port       (s_in_port),
        .s_axis_tuser_out_port      (s_out_port),
        .s_axis_tuser_in_vport      (s_in_vport),
        .s_axis_tuser_out_vport     (s_out_vport),
        .s_axis_tvalid              (s_tvalid),
        .s_axis_tready              (s_tready),
        .s_axis_tlast               (s_tlast),
        .m_axis_tdata               (m_tdata),
        .m_axis_tkeep               (m_tkeep),
        .m_axis_tuser_packet_length (m_plen),
        .m_axis_tuser_in_port       (m_in_port),
        .m_axis_tuser_out_port      (m_out_port),
        .m_axis_tuser_in_vport      (m_in_vport),
        .m_axis_tuser_out_vport     (m_out_vport),
        .m_axis_tvalid              (m_tvalid),
        .m_axis_tready              (m_tready),
`ifdef TKEEP_DECODE_LENGTH_CHECK_EN
        .err_length                 (err_length),
`endif
        .m_axis_tlast               (m_tlast)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bytes 0..k valid, computed as a plain power-of-two minus one.
    function automatic logic [SW-1:0] model_keep(input int k);
        longint unsigned m;
        m = (64'd1 << (k + 1)) - 64'd1;
        return SW'(m);
    endfunction

    task automatic model_accept(input stim_t st);
        exp_t e;
        e.beat.data      = st.data;
        e.beat.keep      = model_keep(int'(st.enc));
        e.beat.plen      = st.plen;
        e.beat.in_port   = st.in_port;
        e.beat.out_port  = st.out_port;
        e.beat.in_vport  = st.in_vport;
        e.beat.out_vport = st.out_vport;
        e.beat.last      = st.last;
        e.acc_cyc        = cyc;
        expq.push_back(e);
        beats_sent++;
        if (mdl_first) mdl_len = int'(st.plen);
        mdl_sum = mdl_sum + int'(st.enc) + 1;
        if (mdl_sum > 32767) mdl_sum = 32767;
        if (st.last) begin
`ifdef TKEEP_DECODE_LENGTH_CHECK_EN
            if (mdl_sum != mdl_len) exp_err++;
`endif
            mdl_sum   = 0;
            mdl_first = 1'b1;
        end else begin
            mdl_first = 1'b0;
        end
    endtask

    task automatic send_beat(input stim_t st);
        int n;
        @(negedge aclk);
        s_tdata     = st.data;
        s_tkeep_enc = st.enc;
        s_plen      = st.plen;
        s_in_port   = st.in_port;
        s_out_port  = st.out_port;
        s_in_vport  = st.in_vport;
        s_out_vport = st.out_vport;
        s_tlast     = st.last;
        s_tvalid    = 1'b1;
        n = 0;
        while (!s_tready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        if (!s_tready) begin
            check("s_ready_timeout", 0, 1);
            s_tvalid = 1'b0;
        end else begin
            model_accept(st);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge aclk);
            s_tvalid = 1'b0;
        end
    endtask

    function automatic stim_t rand_stim(input int enc, input int plen, input bit last);
        stim_t st;
        for (int i = 0; i < DW / 32; i++) st.data[i*32 +: 32] = $urandom;
        st.enc       = EW'(enc);
        st.plen      = PLW'(plen);
        st.in_port   = IPW'($urandom);
        st.out_port  = OPW'($urandom);
        st.in_vport  = IPW'($urandom);
        st.out_vport = OPW'($urandom);
        st.last      = last;
        return st;
    endfunction

    task automatic rand_packet();
        int nb;
        int sum;
        int plen;
        int encs[4];
        nb  = $urandom_range(1, 4);
        sum = 0;
        for (int i = 0; i < nb; i++) begin
            encs[i] = $urandom_range(0, SW - 1);
            sum     = sum + encs[i] + 1;
        end
        plen = ($urandom_range(0, 7) == 0) ? sum + 1 : sum;
        for (int i = 0; i < nb; i++) begin
            send_beat(rand_stim(encs[i], plen, i == nb - 1));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 500) begin
            @(negedge aclk);
            n++;
        end
        check("drain_empty", expq.size(), 0);
        repeat (3) @(negedge aclk);
    endtask

    // Monitor: pops the scoreboard on every handshake, checks hold stability.
    initial begin
        beat_t cur;
        beat_t held;
        bit    hold_prev;
        exp_t  e;
        hold_prev = 1'b0;
        forever begin
            @(negedge aclk);
            #1;
            if (!resetn) begin
                hold_prev = 1'b0;
                expq.delete();
            end else begin
                cur = {m_tdata, m_tkeep, m_plen, m_in_port, m_out_port,
                       m_in_vport, m_out_vport, m_tlast};
                if (hold_prev) check("hold_stable", {m_tvalid, cur}, {1'b1, held});
                if (m_tvalid && m_tready) begin
                    if (expq.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        e = expq.pop_front();
                        check("beat", cur, e.beat);
                        last_latency = cyc - e.acc_cyc;
                        last_beat    = cur;
                        pop_cyc.push_back(cyc);
                    end
                end
                hold_prev = m_tvalid && !m_tready;
                held      = cur;
            end
        end
    end

`ifdef TKEEP_DECODE_LENGTH_CHECK_EN
    initial begin
        forever begin
            @(negedge aclk);
            #1;
            if (resetn && err_length) err_seen++;
        end
    end
`endif

    initial begin
        bit done;
        resetn      = 1'b0;
        s_tvalid    = 1'b0;
        s_tdata     = '0;
        s_tkeep_enc = '0;
        s_plen      = '0;
        s_in_port   = '0;
        s_out_port  = '0;
        s_in_vport  = '0;
        s_out_vport = '0;
        s_tlast     = 1'b0;
        m_tready    = 1'b0;

        // Reset state
        repeat (3) @(negedge aclk);
        #1;
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tkeep", m_tkeep, 0);
        check("rst_m_tlast", m_tlast, 0);
        @(negedge aclk);
        resetn = 1'b1;
        #1 check("ready_at_release", s_tready, 0);
        @(negedge aclk);
        #1 check("ready_first_clock", s_tready, 1);

        // Single beat, enc 5: one-cycle latency and a one-cycle valid pulse
        m_tready = 1'b1;
        send_beat(rand_stim(5, 6, 1'b1));
        idle(1);
        #2;
        check("single_latency", last_latency, 1);
        check("single_keep", last_beat.keep, 32'h0000_003F);
        @(negedge aclk);
        #2 check("single_valid_drop", m_tvalid, 0);

        // 4-beat packet at full rate, 104 bytes
        pop_cyc.delete();
        send_beat(rand_stim(31, 104, 1'b0));
        send_beat(rand_stim(31, 104, 1'b0));
        send_beat(rand_stim(31, 104, 1'b0));
        send_beat(rand_stim(7, 104, 1'b1));
        idle(1);
        drain();
        check("burst_count", pop_cyc.size(), 4);
        if (pop_cyc.size() == 4) check("burst_back_to_back", pop_cyc[3] - pop_cyc[0], 3);
        check("burst_last_keep", last_beat.keep, 32'h0000_00FF);
`ifdef TKEEP_DECODE_LENGTH_CHECK_EN
        check("burst_err_length", err_seen, exp_err);
`endif

        // Backpressure: ready falls after two buffered beats, drain in order
        m_tready = 1'b0;
        fork
            begin
                send_beat(rand_stim(3, 48, 1'b0));
                send_beat(rand_stim(11, 48, 1'b0));
                send_beat(rand_stim(31, 48, 1'b1));
                idle(1);
            end
            begin
                repeat (3) @(negedge aclk);
                check("stall_s_tready", s_tready, 0);
                check("stall_m_tvalid", m_tvalid, 1);
                m_tready = 1'b1;
            end
        join
        drain();

        // Length mismatch: 42 bytes against a declared 40
        send_beat(rand_stim(31, 40, 1'b0));
        send_beat(rand_stim(9, 40, 1'b1));
        idle(1);
        drain();
`ifdef TKEEP_DECODE_LENGTH_CHECK_EN
        check("mismatch_err_length", err_seen, exp_err);
`endif

        // Asynchronous reset while holding two beats of a partial packet
        m_tready = 1'b0;
        send_beat(rand_stim(31, 200, 1'b0));
        send_beat(rand_stim(31, 200, 1'b0));
        @(negedge aclk);
        s_tvalid = 1'b0;
        #1 check("two_s_tready", s_tready, 0);
        #2 resetn = 1'b0;
        #1;
        check("midrst_m_tvalid", m_tvalid, 0);
        check("midrst_s_tready", s_tready, 0);
        check("midrst_m_tlast", m_tlast, 0);
        mdl_first = 1'b1;
        mdl_sum   = 0;
        repeat (2) @(negedge aclk);
        resetn   = 1'b1;
        m_tready = 1'b1;
        @(negedge aclk);
        #1 check("postrst_s_tready", s_tready, 1);
        send_beat(rand_stim(15, 20, 1'b0));
        send_beat(rand_stim(3, 20, 1'b1));
        idle(1);
        drain();
`ifdef TKEEP_DECODE_LENGTH_CHECK_EN
        check("postrst_err_length", err_seen, exp_err);
`endif

        // Random valid/ready traffic, about 1000 beats
        done       = 1'b0;
        beats_sent = 0;
        fork
            begin
                while (beats_sent < 1000) rand_packet();
                idle(1);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge aclk);
                    m_tready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        m_tready = 1'b1;
        drain();
        check("random_beats_sent", beats_sent >= 1000, 1);
`ifdef TKEEP_DECODE_LENGTH_CHECK_EN
        check("random_err_length", err_seen, exp_err);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
